btn_conditioner: RTL and testbench

Parametrised multi-channel front end for pushbuttons and switches. It synchronises, debounces and edge-detects each input, and generates auto-repeat pulses for held buttons. It replaces the per-button debounce and pulser pairs in the top level with one instance, feeding cursor-movement and move-commit pulses to user I/O. Auto-repeat lets a held direction button step the cursor continuously across the board.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_channel.sv | 106 ++++++++++
 rtl/btn_conditioner.sv | 45 ++++
 tb/tb_btn_conditioner.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and counter-width helpers for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} rep_state_t;

    function automatic int db_cnt_width(int db_count);
        return $clog2(db_count + 1);
    endfunction

    function automatic int rep_cnt_width(int delay, int period);
        int m;
        m = (delay > period) ? delay : period;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int DB_W_DEFAULT  = db_cnt_width(1_000_000);
    localparam int REP_W_DEFAULT = rep_cnt_width(32_500_000, 6_500_000);

endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debouncer, edge pulses and auto-repeat FSM for one input
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_COUNT      = 1_000_000,
    parameter int REPEAT_DELAY  = 32_500_000,
    parameter int REPEAT_PERIOD = 6_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    input  logic repeat_en,
    output logic clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W  = db_cnt_width(DB_COUNT);
    localparam int REP_W = rep_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_COUNT - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_W-1:0]        db_cnt, db_cnt_nxt;
    logic                   db_done, rise, fall;
    rep_state_t             state, state_nxt;
    logic [REP_W-1:0]       rep_cnt, rep_cnt_nxt;
    logic                   repeat_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive cycles where sync disagrees with clean; any agreement restarts
    always_comb begin
        db_done    = (sync != clean) && (db_cnt == DB_LAST);
        rise       = db_done && !clean;
        fall       = db_done && clean;
        db_cnt_nxt = (sync == clean || db_done) ? '0 : db_cnt + 1'b1;
    end

    // Repeat FSM next state; release wins over a repeat falling due in the same cycle
    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = '0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: state_nxt = rise ? DELAY : IDLE;
            DELAY: begin
                if (!repeat_en) begin
                    state_nxt = HOLD;
                end else if (rep_cnt == DELAY_LAST) begin
                    state_nxt  = REPEAT;
                    repeat_nxt = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!repeat_en) begin
                    state_nxt = HOLD;
                end else if (rep_cnt == PERIOD_LAST) begin
                    repeat_nxt = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
            end
            default: state_nxt = HOLD;
        endcase
        if (fall) begin
            state_nxt   = IDLE;
            repeat_nxt  = 1'b0;
            rep_cnt_nxt = '0;
        end
    end

    // Repeat FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Synchroniser, debounce state, repeat counter and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            db_cnt        <= '0;
            clean         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            rep_cnt       <= '0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], noisy};
            db_cnt        <= db_cnt_nxt;
            clean         <= clean ^ db_done;
            press_pulse   <= rise;
            release_pulse <= fall;
            repeat_pulse  <= repeat_nxt;
            rep_cnt       <= rep_cnt_nxt;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel button front end producing debounced levels and step pulses
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int CHANNELS      = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_COUNT      = 1_000_000,
    parameter int REPEAT_DELAY  = 32_500_000,
    parameter int REPEAT_PERIOD = 6_500_000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [CHANNELS-1:0] noisy_in,
    input  logic [CHANNELS-1:0] repeat_en_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] press_pulse_out,
    output logic [CHANNELS-1:0] release_pulse_out,
    output logic [CHANNELS-1:0] repeat_pulse_out,
    output logic [CHANNELS-1:0] step_pulse_out
);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            btn_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .DB_COUNT     (DB_COUNT),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD)
            ) u_ch (
                .clk          (clk_in),
                .rst_n        (rst_n_in),
                .noisy        (noisy_in[g]),
                .repeat_en    (repeat_en_in[g]),
                .clean        (clean_out[g]),
                .press_pulse  (press_pulse_out[g]),
                .release_pulse(release_pulse_out[g]),
                .repeat_pulse (repeat_pulse_out[g])
            );
        end
    endgenerate

    assign step_pulse_out = press_pulse_out | repeat_pulse_out;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner with small debounce/repeat counts
module tb_btn_conditioner;

    localparam int CH = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] noisy = '0;
    logic [CH-1:0] en = '0;
    logic [CH-1:0] clean, press, rel_p, rep, step;

    btn_conditioner #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (2),
        .DB_COUNT     (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .noisy_in         (noisy),
        .repeat_en_in     (en),
        .clean_out        (clean),
        .press_pulse_out  (press),
        .release_pulse_out(rel_p),
        .repeat_pulse_out (rep),
        .step_pulse_out   (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int kind;
        int t;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  t0 = 0;
    int  total = 0;
    int  bad = 0;
    bit  mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        return k == 0 ? "press" : k == 1 ? "release" : k == 2 ? "repeat" : "step";
    endfunction

    function automatic void push(int ch, int kind, int t);
        exp_q.push_back('{ch, kind, t});
    endfunction

    function automatic void push_press(int ch, int t);
        push(ch, 0, t);
        push(ch, 3, t);
    endfunction

    function automatic void push_rep(int ch, int t);
        push(ch, 2, t);
        push(ch, 3, t);
    endfunction

    // Scoreboard: every observed pulse must match a pending expectation; overdue ones are missing
    always @(negedge clk) begin : mon
        int rel;
        int idx;
        logic [CH-1:0] v;
        if (mon_on) begin
            rel = cyc - t0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].t < rel) begin
                    total++;
                    bad++;
                    $display("FAIL missing ch%0d %s: seen none, required at cycle %0d (now %0d)",
                             exp_q[i].ch, kname(exp_q[i].kind), exp_q[i].t, rel);
                    exp_q.delete(i);
                end
            end
            for (int k = 0; k < 4; k++) begin
                v = k == 0 ? press : k == 1 ? rel_p : k == 2 ? rep : step;
                for (int c = 0; c < CH; c++) begin
                    if (v[c]) begin
                        idx = -1;
                        for (int j = 0; j < exp_q.size(); j++)
                            if (exp_q[j].ch == c && exp_q[j].kind == k && exp_q[j].t == rel) idx = j;
                        total++;
                        if (idx < 0) begin
                            bad++;
                            $display("FAIL unexpected ch%0d %s: seen at cycle %0d, required none", c, kname(k), rel);
                        end else begin
                            exp_q.delete(idx);
                        end
                    end
                end
            end
        end
    end

    task automatic start();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic go(int r);
        while (cyc < t0 + r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        noisy = '1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({clean, press, rel_p, rep, step} !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h, required 0", {clean, press, rel_p, rep, step});
        end
        noisy = '0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({clean, press, rel_p, rep, step} !== '0) begin
            bad++;
            $display("FAIL post_reset_idle: got %h, required 0", {clean, press, rel_p, rep, step});
        end
        mon_on = 1'b1;
    endtask

    task automatic test_clean_press();
        start();
        noisy[0] = 1'b1;
        push_press(0, 6);
        go(5);
        total++;
        if (clean[0] !== 1'b0) begin
            bad++;
            $display("FAIL press_early ch0 clean: got %b, required 0", clean[0]);
        end
        go(6);
        total++;
        if (clean[0] !== 1'b1) begin
            bad++;
            $display("FAIL press_latency ch0 clean: got %b, required 1", clean[0]);
        end
        go(106);
        total++;
        if (clean[0] !== 1'b1) begin
            bad++;
            $display("FAIL held ch0 clean: got %b, required 1", clean[0]);
        end
        noisy[0] = 1'b0;
        push(0, 1, 112);
        go(111);
        total++;
        if (clean[0] !== 1'b1) begin
            bad++;
            $display("FAIL release_early ch0 clean: got %b, required 1", clean[0]);
        end
        go(112);
        total++;
        if (clean[0] !== 1'b0) begin
            bad++;
            $display("FAIL release_latency ch0 clean: got %b, required 0", clean[0]);
        end
        go(120);
    endtask

    task automatic test_bounce();
        start();
        noisy[1] = 1'b1;
        go(3);
        noisy[1] = 1'b0;
        go(4);
        noisy[1] = 1'b1;
        go(7);
        noisy[1] = 1'b0;
        for (int r = 8; r <= 30; r += 4) begin
            go(r);
            total++;
            if (clean[1] !== 1'b0) begin
                bad++;
                $display("FAIL bounce ch1 clean at %0d: got %b, required 0", r, clean[1]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        en[2] = 1'b1;
        start();
        noisy[2] = 1'b1;
        push_press(2, 6);
        push_rep(2, 26);
        push_rep(2, 34);
        push_rep(2, 42);
        go(43);
        noisy[2] = 1'b0;
        push(2, 1, 49);
        go(70);
        en[2] = 1'b0;
    endtask

    task automatic test_release_priority();
        en[3] = 1'b1;
        start();
        noisy[3] = 1'b1;
        push_press(3, 6);
        push_rep(3, 26);
        push_rep(3, 34);
        push_rep(3, 42);
        go(44);
        noisy[3] = 1'b0;
        push(3, 1, 50);
        go(50);
        total++;
        if ({rep[3], rel_p[3]} !== 2'b01) begin
            bad++;
            $display("FAIL release_priority ch3 {repeat,release}: got %b, required 01", {rep[3], rel_p[3]});
        end
        go(65);
        en[3] = 1'b0;
    endtask

    task automatic test_enable_drop();
        en[2] = 1'b1;
        start();
        noisy[2] = 1'b1;
        push_press(2, 6);
        push_rep(2, 26);
        go(30);
        en[2] = 1'b0;
        go(34);
        total++;
        if (rep[2] !== 1'b0) begin
            bad++;
            $display("FAIL enable_drop ch2 repeat at 34: got %b, required 0", rep[2]);
        end
        go(35);
        en[2] = 1'b1;
        go(60);
        noisy[2] = 1'b0;
        push(2, 1, 66);
        go(75);
        en[2] = 1'b0;
    endtask

    task automatic test_async_reset();
        en[2] = 1'b1;
        start();
        noisy[2] = 1'b1;
        push_press(2, 6);
        push_rep(2, 26);
        go(29);
        total++;
        if (clean[2] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset ch2 clean: got %b, required 1", clean[2]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({clean, press, rel_p, rep, step} !== '0) begin
            bad++;
            $display("FAIL async_reset outputs: got %h, required 0", {clean, press, rel_p, rep, step});
        end
        go(40);
        rst_n = 1'b1;
        push_press(2, 46);
        push_rep(2, 66);
        push_rep(2, 74);
        go(70);
        noisy[2] = 1'b0;
        push(2, 1, 76);
        go(85);
        en[2] = 1'b0;
    endtask

    task automatic test_independence();
        int p, d;
        start();
        for (int r = 0; r <= 60; r++) begin
            go(r);
            for (int k = 0; k < CH; k++) begin
                p = 3 * k;
                d = 40 + 5 * k;
                if (r == p) begin
                    en[k] = (k != 1);
                    noisy[k] = 1'b1;
                    push_press(k, p + 6);
                    if (k != 1)
                        for (int t = p + 26; t < d + 6; t += 8) push_rep(k, t);
                end
                if (r == d) begin
                    noisy[k] = 1'b0;
                    push(k, 1, d + 6);
                end
            end
        end
        go(80);
        total++;
        if (clean !== '0) begin
            bad++;
            $display("FAIL independence final clean: got %b, required 00000", clean);
        end
        en = '0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_priority();
        test_enable_drop();
        test_async_reset();
        test_independence();
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover expectations: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
